// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - Sudoku game-control FSM; optional MAIN_FSM_ATTEMPT_LIMIT_EN caps failed checks
module main_fsm (
    input  logic       clka,
    input  logic       restart,
    input  logic       enter,
    input  logic       check,
    input  logic       solved,
    output logic       gen_rand_flag,
    output logic       set_board_flag,
    output logic       set_diff_flag,
    output logic       play_flag,
    output logic       check_flag,
    output logic       win_flag,
    output logic       try_again_flag,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SET_DIFF  = 3'd1,
        ST_GEN_RAND  = 3'd2,
        ST_SET_BOARD = 3'd3,
        ST_PLAY      = 3'd4,
        ST_CHECK     = 3'd5,
        ST_WIN       = 3'd6,
        ST_TRY_AGAIN = 3'd7
    } state_t;

    state_t state_q, state_d;

`ifdef MAIN_FSM_ATTEMPT_LIMIT_EN
    logic [1:0] fail_cnt_q, fail_cnt_d;

    always_ff @(posedge clka or posedge restart) begin
        if (restart) fail_cnt_q <= 2'd0;
        else         fail_cnt_q <= fail_cnt_d;
    end
`endif

    always_ff @(posedge clka or posedge restart) begin
        if (restart) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
`ifdef MAIN_FSM_ATTEMPT_LIMIT_EN
        fail_cnt_d = fail_cnt_q;
`endif
        case (state_q)
            ST_IDLE:      if (enter) state_d = ST_SET_DIFF;
            ST_SET_DIFF:  if (enter) state_d = ST_GEN_RAND;
            ST_GEN_RAND:  state_d = ST_SET_BOARD;
            ST_SET_BOARD: begin
                if (enter) begin
                    state_d = ST_PLAY;
`ifdef MAIN_FSM_ATTEMPT_LIMIT_EN
                    fail_cnt_d = 2'd0;
`endif
                end
            end
            // enter in PLAY is a cell entry handled by the datapath
            ST_PLAY:      if (check) state_d = ST_CHECK;
            ST_CHECK: begin
                if (solved) begin
                    state_d = ST_WIN;
                end else begin
`ifdef MAIN_FSM_ATTEMPT_LIMIT_EN
                    if (fail_cnt_q == 2'd3) begin
                        state_d    = ST_IDLE;
                        fail_cnt_d = 2'd0;
                    end else begin
                        state_d    = ST_TRY_AGAIN;
                        fail_cnt_d = fail_cnt_q + 2'd1;
                    end
`else
                    state_d = ST_TRY_AGAIN;
`endif
                end
            end
            ST_WIN:       if (enter) state_d = ST_IDLE;
            ST_TRY_AGAIN: if (enter) state_d = ST_PLAY;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gen_rand_flag  = 1'b0;
        set_board_flag = 1'b0;
        set_diff_flag  = 1'b0;
        play_flag      = 1'b0;
        check_flag     = 1'b0;
        win_flag       = 1'b0;
        try_again_flag = 1'b0;
        case (state_q)
            ST_SET_DIFF:  set_diff_flag  = 1'b1;
            ST_GEN_RAND:  gen_rand_flag  = 1'b1;
            ST_SET_BOARD: set_board_flag = 1'b1;
            ST_PLAY:      play_flag      = 1'b1;
            ST_CHECK:     check_flag     = 1'b1;
            ST_WIN:       win_flag       = 1'b1;
            ST_TRY_AGAIN: try_again_flag = 1'b1;
            default:      ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - directed self-checking bench for main_fsm
module tb_main_fsm;

    logic       clka = 1'b0;
    logic       restart, enter, check, solved;
    logic       gen_rand_flag, set_board_flag, set_diff_flag, play_flag;
    logic       check_flag, win_flag, try_again_flag;
    logic [2:0] state;
    logic [6:0] flags;

    int total = 0;
    int bad   = 0;

    main_fsm dut (
        .clka           (clka),
        .restart        (restart),
        .enter          (enter),
        .check          (check),
        .solved         (solved),
        .gen_rand_flag  (gen_rand_flag),
        .set_board_flag (set_board_flag),
        .set_diff_flag  (set_diff_flag),
        .play_flag      (play_flag),
        .check_flag     (check_flag),
        .win_flag       (win_flag),
        .try_again_flag (try_again_flag),
        .state          (state)
    );

    always #5 clka = ~clka;

    assign flags = {try_again_flag, win_flag, check_flag, play_flag,
                    set_board_flag, gen_rand_flag, set_diff_flag};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected flag vector: bit (code-1) set, nothing in IDLE
    task automatic chk_st(input string tag, input logic [2:0] exp_st);
        logic [6:0] exp_fl;
        exp_fl = (exp_st == 3'd0) ? 7'd0 : (7'd1 << (exp_st - 3'd1));
        chk({tag, "_state"}, {29'd0, state}, {29'd0, exp_st});
        chk({tag, "_flags"}, {25'd0, flags}, {25'd0, exp_fl});
    endtask

    task automatic tick(input logic e, input logic c, input logic s);
        enter  = e;
        check  = c;
        solved = s;
        @(posedge clka);
        #1;
    endtask

    initial begin
        restart = 1'b1;
        enter   = 1'b1;
        check   = 1'b0;
        solved  = 1'b0;
        #1;
        chk_st("reset_async", 3'd0);
        tick(1, 0, 0); chk_st("reset_hold1", 3'd0);
        tick(1, 0, 0); chk_st("reset_hold2", 3'd0);
        restart = 1'b0;
        enter   = 1'b0;

        tick(0, 0, 0); chk_st("e1_idle", 3'd0);
        tick(0, 0, 0); chk_st("e2_idle", 3'd0);
        tick(1, 0, 0); chk_st("e3_setdiff", 3'd1);
        tick(0, 0, 0); chk_st("e4_setdiff_hold", 3'd1);
        tick(1, 0, 0); chk_st("e5_genrand", 3'd2);
        tick(0, 0, 0); chk_st("e6_setboard", 3'd3);
        tick(1, 0, 0); chk_st("e7_play", 3'd4);
        tick(0, 0, 0); chk_st("e8_play", 3'd4);
        tick(1, 0, 0); chk_st("e9_play_enter", 3'd4);
        tick(0, 1, 0); chk_st("e10_check", 3'd5);
        tick(0, 0, 0); chk_st("e11_tryagain", 3'd7);
        chk("try_again_flag", {31'd0, try_again_flag}, 32'd1);
        tick(0, 1, 1); chk_st("tryagain_hold", 3'd7);

        tick(1, 0, 0); chk_st("retry_play", 3'd4);
        chk("play_flag", {31'd0, play_flag}, 32'd1);
        tick(1, 1, 0); chk_st("enter_check_both", 3'd5);
        tick(0, 0, 1); chk_st("win", 3'd6);
        chk("win_flag", {31'd0, win_flag}, 32'd1);
        tick(0, 1, 0); chk_st("win_hold", 3'd6);
        tick(1, 0, 0); chk_st("win_to_idle", 3'd0);

        tick(1, 0, 0); chk_st("held_setdiff", 3'd1);
        tick(1, 0, 0); chk_st("held_genrand", 3'd2);
        tick(1, 1, 0); chk_st("held_setboard", 3'd3);
        tick(1, 1, 0); chk_st("held_play", 3'd4);
        tick(1, 0, 0); chk_st("held_play_stay", 3'd4);

        enter = 1'b0;
        #2;
        restart = 1'b1;
        #1;
        chk_st("midgame_reset", 3'd0);
        #2;
        restart = 1'b0;
        tick(0, 0, 0); chk_st("after_reset", 3'd0);

        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0); chk_st("limit_play", 3'd4);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0); chk_st($sformatf("limit_chk%0d", i), 3'd5);
            tick(0, 0, 0);
`ifdef MAIN_FSM_ATTEMPT_LIMIT_EN
            chk_st($sformatf("limit_fail%0d", i), (i < 3) ? 3'd7 : 3'd0);
`else
            chk_st($sformatf("limit_fail%0d", i), 3'd7);
`endif
            if (i < 3) begin
                tick(1, 0, 0); chk_st($sformatf("limit_retry%0d", i), 3'd4);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
